// File: rtl/csr_spmv_pkg.sv
// Shared types and defaults for the CSR SpMV row-accumulation datapath.
// Holds the row accumulator FSM state encoding and the signed-overflow helper.
package csr_spmv_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 24;
  localparam int DEF_ROW_W  = 16;
  localparam int DEF_BLK_W  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  typedef logic signed [DEF_ACC_W-1:0] acc_t;
  typedef logic        [DEF_ROW_W-1:0] row_t;

  // Two's-complement add overflows when both operands share a sign the result lacks.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/rowacc_cs_adder.sv
// Combinational W-bit carry-select adder built from BLK_W-bit blocks, carry-in 0.
// Reports signed overflow of the W-bit two's-complement sum.
module rowacc_cs_adder
  import csr_spmv_pkg::*;
#(
  parameter int W     = DEF_ACC_W,
  parameter int BLK_W = DEF_BLK_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam int NBLK = (W + BLK_W - 1) / BLK_W;
  localparam int PW   = NBLK * BLK_W;

  logic [PW-1:0]    a_p;
  logic [PW-1:0]    b_p;
  logic [PW-1:0]    s_p;
  logic [BLK_W:0]   blk0;
  logic [BLK_W:0]   blk1;
  logic             carry;

  assign a_p = PW'(a);
  assign b_p = PW'(b);

  // Each block precomputes both carry-in outcomes; the ripple only steers muxes.
  always_comb begin
    s_p   = '0;
    blk0  = '0;
    blk1  = '0;
    carry = 1'b0;
    for (int i = 0; i < NBLK; i++) begin
      blk0 = {1'b0, a_p[i*BLK_W +: BLK_W]} + {1'b0, b_p[i*BLK_W +: BLK_W]};
      blk1 = {1'b0, a_p[i*BLK_W +: BLK_W]} + {1'b0, b_p[i*BLK_W +: BLK_W]} + (BLK_W+1)'(1);
      s_p[i*BLK_W +: BLK_W] = carry ? blk1[BLK_W-1:0] : blk0[BLK_W-1:0];
      carry = carry ? blk1[BLK_W] : blk0[BLK_W];
    end
  end

  assign sum = s_p[W-1:0];
  assign ovf = signed_ovf(a[W-1], b[W-1], sum[W-1]);

endmodule

// File: rtl/csr_row_accumulator.sv
// Sums signed partial products per CSR row and emits one (sum, row, overflow) beat per row.
// Build option ROWACC_SAT_EN: clamp the accumulator on overflow instead of wrapping.
module csr_row_accumulator
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int ROW_W  = DEF_ROW_W,
  parameter int BLK_W  = DEF_BLK_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [ROW_W-1:0]  out_row,
  output logic              out_ovf
);

  // Handshake: a beat moves on a side when valid & ready are both high at the rising
  // edge; valid never waits on ready, and payload is held stable while valid & !ready.

`ifdef ROWACC_SAT_EN
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic [ROW_W-1:0]   out_row_q, out_row_d;
  logic               out_ovf_q, out_ovf_d;

  logic               first;
  logic               accept;
  logic [ACC_W-1:0]   acc_base;
  logic [ACC_W-1:0]   addend;
  logic [ACC_W-1:0]   add_sum;
  logic               add_ovf;
  logic [ACC_W-1:0]   acc_new;
  logic               row_ovf;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign first    = (state_q == IDLE);
  assign acc_base = first ? '0 : acc_q;
  assign addend   = ACC_W'($signed(in_data));

  rowacc_cs_adder #(
    .W     (ACC_W),
    .BLK_W (BLK_W)
  ) u_adder (
    .a   (acc_base),
    .b   (addend),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  assign row_ovf = (!first && ovf_q) || add_ovf;

`ifdef ROWACC_SAT_EN
  // Once a row has saturated it stays pinned to the clamp value until it ends.
  always_comb begin
    acc_new = add_sum;
    if (!first && ovf_q) begin
      acc_new = acc_q;
    end else if (add_ovf) begin
      acc_new = addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
    end
  end
`else
  assign acc_new = add_sum;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    row_cnt_d   = row_cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_row_d   = out_row_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (in_last || in_empty) begin
        // An empty row reports zero and no overflow regardless of the adder result.
        out_valid_d = 1'b1;
        out_sum_d   = in_empty ? '0 : acc_new;
        out_ovf_d   = !in_empty && row_ovf;
        out_row_d   = row_cnt_q;
        row_cnt_d   = row_cnt_q + ROW_W'(1);
        state_d     = IDLE;
        acc_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d   = acc_new;
        ovf_d   = row_ovf;
        state_d = ACC;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      row_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_row_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      row_cnt_q   <= row_cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_row_q   <= out_row_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_row   = out_row_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_csr_row_accumulator.sv
// Scoreboard bench for csr_row_accumulator: directed rows plus a random row stream,
// and a narrow 16-bit accumulator instance for the overflow boundary.
module tb_csr_row_accumulator;

  localparam int DW    = 16;
  localparam int AW    = 24;
  localparam int RW    = 16;
  localparam int EXP_W = 1 + RW + AW;

  logic clk;
  logic rst_n;

  logic          in_valid, in_ready, in_last, in_empty;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_ovf;
  logic [AW-1:0] out_sum;
  logic [RW-1:0] out_row;

  logic          v_in_valid, v_in_ready, v_in_last, v_in_empty;
  logic [15:0]   v_in_data;
  logic          v_out_valid, v_out_ready, v_out_ovf;
  logic [15:0]   v_out_sum;
  logic [RW-1:0] v_out_row;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EXP_W-1:0] exp_q[$];

  logic [AW-1:0] m_acc;
  logic          m_ovf;
  logic          m_first;
  logic [RW-1:0] m_row;

  csr_row_accumulator #(.DATA_W(DW), .ACC_W(AW), .ROW_W(RW), .BLK_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_row   (out_row),
    .out_ovf   (out_ovf)
  );

  csr_row_accumulator #(.DATA_W(16), .ACC_W(16), .ROW_W(RW), .BLK_W(4)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (v_in_valid),
    .in_ready  (v_in_ready),
    .in_data   (v_in_data),
    .in_last   (v_in_last),
    .in_empty  (v_in_empty),
    .out_valid (v_out_valid),
    .out_ready (v_out_ready),
    .out_sum   (v_out_sum),
    .out_row   (v_out_row),
    .out_ovf   (v_out_ovf)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_acc   = '0;
    m_ovf   = 1'b0;
    m_first = 1'b1;
    m_row   = '0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic last, input logic empty);
    logic [AW-1:0] base, add, r;
    logic          o;
    if (empty) begin
      exp_q.push_back({1'b0, m_row, {AW{1'b0}}});
      m_row++;
      m_first = 1'b1;
      m_acc   = '0;
      m_ovf   = 1'b0;
    end else begin
      base = m_first ? '0 : m_acc;
      add  = {{(AW-DW){d[DW-1]}}, d};
      r    = base + add;
      o    = ((base[AW-1] == add[AW-1]) && (r[AW-1] != base[AW-1])) || (!m_first && m_ovf);
      if (last) begin
        exp_q.push_back({o, m_row, r});
        m_row++;
        m_first = 1'b1;
        m_acc   = '0;
        m_ovf   = 1'b0;
      end else begin
        m_acc   = r;
        m_ovf   = o;
        m_first = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [DW-1:0] d, input logic last, input logic empty,
                           input bit rnd_ready, output bit stalled);
    int waits;
    waits   = 0;
    stalled = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    #1;
    while (!in_ready) begin
      stalled = 1'b1;
      waits++;
      if (waits > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, expected 1", waits);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
      #1;
    end
    @(posedge clk);
    model_beat(d, last, empty);
  endtask

  task automatic go_idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic v_send(input logic [15:0] d, input logic last);
    @(negedge clk);
    v_in_valid = 1'b1;
    v_in_data  = d;
    v_in_last  = last;
  endtask

  task automatic v_end_row(input logic [15:0] exp_sum, input logic [RW-1:0] exp_row);
    @(negedge clk);
    v_in_valid = 1'b0;
    v_in_last  = 1'b0;
    #2;
    check("ovf16_valid", 64'(v_out_valid), 64'd1);
    check("ovf16_sum", 64'(v_out_sum), 64'(exp_sum));
    check("ovf16_ovf", 64'(v_out_ovf), 64'd1);
    check("ovf16_row", 64'(v_out_row), 64'(exp_row));
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] mon_exp;
  always begin
    @(negedge clk);
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got sum=0x%0h row=%0d with no expected entry", out_sum, out_row);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_sum", 64'(out_sum), 64'(mon_exp[AW-1:0]));
        check("out_row", 64'(out_row), 64'(mon_exp[AW+RW-1:AW]));
        check("out_ovf", 64'(out_ovf), 64'(mon_exp[EXP_W-1]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit st;
    int len;
    int val;

    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_last     = 1'b0;
    in_empty    = 1'b0;
    out_ready   = 1'b1;
    v_in_valid  = 1'b0;
    v_in_data   = '0;
    v_in_last   = 1'b0;
    v_in_empty  = 1'b0;
    v_out_ready = 1'b1;
    model_reset();

    repeat (3) @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_sum", 64'(out_sum), 64'd0);
    check("reset_out_row", 64'(out_row), 64'd0);
    check("reset_out_ovf", 64'(out_ovf), 64'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Row {3,5,-2} -> 6, row 0
    send_beat(16'd3, 1'b0, 1'b0, 1'b0, st);
    send_beat(16'd5, 1'b0, 1'b0, 1'b0, st);
    send_beat(-16'sd2, 1'b1, 1'b0, 1'b0, st);
    go_idle();
    wait_drain();

    // Back-to-back single-beat rows 7,-1,0 with no stall
    send_beat(16'd7, 1'b1, 1'b0, 1'b0, st);
    check("b2b_in_ready_0", 64'(st), 64'd0);
    send_beat(-16'sd1, 1'b1, 1'b0, 1'b0, st);
    check("b2b_in_ready_1", 64'(st), 64'd0);
    send_beat(16'd0, 1'b1, 1'b0, 1'b0, st);
    check("b2b_in_ready_2", 64'(st), 64'd0);
    go_idle();
    wait_drain();

    // Empty row sandwiched between two real rows
    send_beat(16'd5, 1'b1, 1'b0, 1'b0, st);
    send_beat(16'hABCD, 1'b0, 1'b1, 1'b0, st);
    send_beat(16'd9, 1'b1, 1'b0, 1'b0, st);
    go_idle();
    wait_drain();
    check("row_count_after_empty", 64'(m_row), 64'd7);

    // Downstream stall for 5 cycles
    out_ready = 1'b0;
    send_beat(16'd42, 1'b1, 1'b0, 1'b0, st);
    go_idle();
    for (int i = 0; i < 5; i++) begin
      #2;
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_out_sum", 64'(out_sum), 64'd42);
      check("stall_out_row", 64'(out_row), 64'd7);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    #2;
    check("stall_released_valid", 64'(out_valid), 64'd0);

    // Narrow 16-bit accumulator overflow boundary
    v_send(16'h7FFF, 1'b0);
    v_send(16'h0001, 1'b1);
`ifdef ROWACC_SAT_EN
    v_end_row(16'h7FFF, 16'd0);
`else
    v_end_row(16'h8000, 16'd0);
`endif
    v_send(16'h8000, 1'b0);
    v_send(16'hFFFF, 1'b1);
`ifdef ROWACC_SAT_EN
    v_end_row(16'h8000, 16'd1);
`else
    v_end_row(16'h7FFF, 16'd1);
`endif
    v_send(16'h7FFF, 1'b0);
    v_send(16'h0001, 1'b0);
    v_send(16'hFFFB, 1'b1);
`ifdef ROWACC_SAT_EN
    v_end_row(16'h7FFF, 16'd2);
`else
    v_end_row(16'h7FFB, 16'd2);
`endif

    // Random row stream with random downstream back-pressure
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        send_beat(16'($urandom_range(0, 65535)), 1'b1, 1'b1, 1'b1, st);
      end else begin
        len = $urandom_range(1, 4);
        for (int b = 0; b < len; b++) begin
          val = int'($urandom_range(0, 65534)) - 32767;
          send_beat(16'(val), (b == len - 1), 1'b0, 1'b1, st);
        end
      end
    end
    go_idle();
    out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of row {10,20}, then row {4}
    send_beat(16'd10, 1'b0, 1'b0, 1'b0, st);
    send_beat(16'd20, 1'b0, 1'b0, 1'b0, st);
    go_idle();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_out_row", 64'(out_row), 64'd0);
    rst_n = 1'b1;
    send_beat(16'd4, 1'b1, 1'b0, 1'b0, st);
    go_idle();
    wait_drain();

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
